fifo_read_arbiter: RTL and testbench
====================================

Name: fifo_read_arbiter

Overview:
- Round-robin scheduler that shares the single read port of the async FIFO among NREQ consumers, all in the read clock domain.
- Takes the FIFO's registered rempty flag and read data.
- Drives the FIFO's rout pop strobe.
- Steers a valid/ready read handshake to exactly one granted consumer at a time.
- Caps each grant at BURST pops so no consumer can starve the others.

Parameters:
- NREQ, 4, number of consumers (2..16).
- DATASIZE, 8, FIFO read-data width.
- BURST, 8, max pops per grant (>=1).
- TIMEOUT, 16, stall cycles before forced release; used only with FIFO_ARB_WDOG_EN.

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  reset, synchronous, active-low.
- rempty  in  1  FIFO empty flag (registered in the FIFO).
- rdata  in  DATASIZE  FIFO read data at current read address.
- rout  out  1  pop strobe to FIFO.
- req  in  NREQ  per-consumer request, level.
- rd_ready  in  NREQ  per-consumer ready.
- gnt  out  NREQ  one-hot grant, registered.
- rd_valid  out  NREQ  per-consumer data valid.
- rd_data  out  DATASIZE  rdata broadcast to all consumers.
- busy  out  1  high in GRANT or RELEASE.

Behaviour:
- Single clock, synchronous active-low reset.
- Reset values:
  - state=IDLE, gnt=0, busy=0, rout=0, rd_valid=0.
  - burst counter=0.
  - rr pointer=0, so consumer 0 has highest priority first.
- rd_data = rdata, combinational passthrough.
- rd_valid[i] = (state==GRANT) & gnt[i] & ~rempty.
- rout = |(rd_valid & rd_ready). This guarantees rout is never high while rempty=1; it is at most one pop per cycle.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If |req, pick the first set req bit at or after rr pointer, wrapping modulo NREQ.
  - Register the one-hot gnt, clear the burst counter, go to GRANT next cycle.
  - Grant latency from req to gnt is 1 cycle.
  - With no req, stay in IDLE.
- GRANT:
  - The burst counter increments on each rout.
  - Go to RELEASE on any of:
    - req[granted] deasserts, evaluated the same cycle;
    - rout occurs while the counter equals BURST-1, i.e. the BURST-th pop;
    - watchdog expiry (see Optional Feature).
  - gnt and rd_valid stay high through the final pop cycle.
  - The final pop completes normally.
- RELEASE:
  - gnt=0, rout=0.
  - rr pointer = granted index + 1, mod NREQ.
  - Go to IDLE next cycle.
  - This is a 1-cycle turnaround, so back-to-back grants are spaced 2 cycles apart.
- rempty=1 in GRANT: no pop and no release; the grant holds while req stays high.
- Counter width is clog2(BURST)+1 bits. It never wraps because release happens at BURST.
- req deasserting in the same cycle as a pop: the pop still counts, then RELEASE.
- A consumer must not change rd_ready behaviour based on gnt of another index. Only its own gnt/rd_valid matter.
- Reset mid-burst: next cycle all outputs are at reset values and rr=0. No pop is issued in the reset cycle.

Optional Feature:
- Macro: FIFO_ARB_WDOG_EN.
- When defined:
  - A stall counter in GRANT increments each cycle with rd_valid high and rd_ready low for the granted consumer.
  - It clears on any rout or state change.
  - When it reaches TIMEOUT, go to RELEASE.
  - Sticky output wdog_err (1 bit, reset 0) sets and stays until reset.
- When undefined:
  - No stall counter and no wdog_err port.
  - A grant holds indefinitely while req stays high.

Test Plan:
- Reset, FIFO holds 3 words, req=4'b0001, rd_ready=1:
  - gnt=0001 one cycle after req;
  - rout high 3 consecutive cycles, then rempty=1 stops pops;
  - grant held while req stays high.
- req=4'b1111, FIFO never empty, rd_ready all 1, BURST=8:
  - grant order 0,1,2,3,0;
  - exactly 8 pops per grant;
  - 2-cycle gap between grants.
- Grant on consumer 2, consumer 2 drops req after 3 pops:
  - RELEASE after the 3rd pop;
  - next grant goes to the lowest requester at index >=3, wrapping.
- rempty=1 with gnt active, rd_ready=1:
  - rout and rd_valid stay 0 for all cycles until rempty=0;
  - a pop then occurs the same cycle rempty falls.
- Assert rrst_n=0 mid-burst after 4 pops:
  - next edge gives gnt=0, rout=0, state IDLE;
  - after release, req=1111 grants consumer 0 first.
- FIFO_ARB_WDOG_EN, TIMEOUT=16, granted consumer holds rd_ready=0 with data available:
  - forced RELEASE after 16 stall cycles;
  - wdog_err=1 and stays 1;
  - next requester is granted.

Source files
------------

// File: rtl/fifo_read_arbiter.sv
// rtl/fifo_read_arbiter.sv - round-robin arbiter sharing one async-FIFO read port among NREQ consumers
// Optional stall watchdog with sticky wdog_err output: define FIFO_ARB_WDOG_EN.
module fifo_read_arbiter #(
  parameter int NREQ     = 4,
  parameter int DATASIZE = 8,
  parameter int BURST    = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rout,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     rd_ready,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rd_valid,
  output logic [DATASIZE-1:0] rd_data,
`ifdef FIFO_ARB_WDOG_EN
  output logic                wdog_err,
`endif
  output logic                busy
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = $clog2(BURST) + 1;

  if (NREQ < 2 || NREQ > 16 || BURST < 1 || TIMEOUT < 1) begin : g_param_check
    $error("fifo_read_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] gnt_idx;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] cand;
  logic [IDXW-1:0] rr_next;
  logic            pick_found;
  logic [CNTW-1:0] burst_cnt;
  logic            last_pop;
  logic            release_now;
  logic            wdog_fire;

  assign rd_data = rdata;

  // Gating with rrst_n keeps a reset cycle from popping the FIFO while state is still GRANT.
  assign rd_valid    = gnt & {NREQ{(state == GRANT) && !rempty && rrst_n}};
  assign rout        = |(rd_valid & rd_ready);
  assign last_pop    = rout && (burst_cnt == CNTW'(BURST - 1));
  assign release_now = (state == GRANT) && (!req[gnt_idx] || last_pop || wdog_fire);
  assign rr_next     = (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDXW'((int'(rr_ptr) + k) % NREQ);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt       <= NREQ'(1) << pick_idx;
            gnt_idx   <= pick_idx;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (rout) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (release_now) begin
            gnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          rr_ptr <= rr_next;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_WDOG_EN
  localparam int SW = $clog2(TIMEOUT) + 1;

  logic [SW-1:0] stall_cnt;
  logic          stall;

  assign stall     = |(rd_valid & ~rd_ready);
  assign wdog_fire = stall && (stall_cnt == SW'(TIMEOUT - 1));

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      stall_cnt <= '0;
      wdog_err  <= 1'b0;
    end else begin
      if ((state != GRANT) || rout || release_now) begin
        stall_cnt <= '0;
      end else if (stall) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (wdog_fire) begin
        wdog_err <= 1'b1;
      end
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb/tb_fifo_read_arbiter.sv - scoreboard bench for fifo_read_arbiter
module tb_fifo_read_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int BURST   = 8;
  localparam int TIMEOUT = 16;

  logic            rclk = 1'b0;
  logic            rrst_n;
  logic            rempty;
  logic            rout;
  logic            busy;
  logic [DW-1:0]   rdata;
  logic [DW-1:0]   rd_data;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] rd_ready;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rd_valid;
`ifdef FIFO_ARB_WDOG_EN
  logic            wdog_err;
`endif

  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int exp_idx  = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            who;
    logic [DW-1:0] data;
  } pop_t;

  pop_t            exp_q[$];
  pop_t            mon_e;
  logic [NREQ-1:0] mon_v;
  int              mon_who;
  logic [NREQ-1:0] eg;

  fifo_read_arbiter #(
    .NREQ(NREQ), .DATASIZE(DW), .BURST(BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .rclk(rclk),
    .rrst_n(rrst_n),
    .rempty(rempty),
    .rdata(rdata),
    .rout(rout),
    .req(req),
    .rd_ready(rd_ready),
    .gnt(gnt),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
`ifdef FIFO_ARB_WDOG_EN
    .wdog_err(wdog_err),
`endif
    .busy(busy)
  );

  always #5 rclk = ~rclk;

  // FIFO model: word n holds n*7+3; wr_cnt marks how many words were written.
  assign rempty = (rd_cnt >= wr_cnt);
  assign rdata  = DW'(rd_cnt * 7 + 3);

  always @(posedge rclk) begin
    if (rout) rd_cnt <= rd_cnt + 1;
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_pops(input int who, input int n);
    for (int k = 0; k < n; k++) begin
      pop_t p;
      p.who  = who;
      p.data = DW'(exp_idx * 7 + 3);
      exp_q.push_back(p);
      exp_idx++;
    end
  endtask

  task automatic do_reset();
    tick();
    rrst_n = 1'b0;
    req    = '0;
    tick();
    rrst_n = 1'b1;
  endtask

  always @(negedge rclk) begin
    if (rout) begin
      mon_v   = rd_valid & rd_ready;
      mon_who = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (mon_v == (4'b0001 << i)) mon_who = i;
      end
      chk("pop_while_empty", 32'(rempty), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual=consumer %0d expected=no pop", mon_who);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_consumer", mon_who, mon_e.who);
        chk("pop_data", 32'(rd_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    rrst_n   = 1'b0;
    req      = '0;
    rd_ready = '0;
    repeat (2) tick();
    @(negedge rclk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rout", 32'(rout), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);

    // Three buffered words, single requester
    tick();
    rrst_n   = 1'b1;
    rd_ready = 4'b1111;
    req      = 4'b0001;
    wr_cnt   = exp_idx + 3;
    expect_pops(0, 3);
    @(negedge rclk);
    chk("grant_latency_zero", 32'(gnt), 32'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge rclk);
      chk("t1_gnt_held", 32'(gnt), 32'b0001);
      chk("t1_rout", 32'(rout), (c < 3) ? 32'd1 : 32'd0);
    end
    tick();
    req = '0;
    tick();
    @(negedge rclk);
    chk("t1_release_busy", 32'(busy), 32'd1);
    chk("t1_release_gnt", 32'(gnt), 32'd0);

    // All requesting, FIFO never empty: 0,1,2,3,0 with 8 pops each and a 2-cycle gap
    do_reset();
    wr_cnt = 1 << 30;
    req    = 4'b1111;
    expect_pops(0, 8);
    expect_pops(1, 8);
    expect_pops(2, 8);
    expect_pops(3, 8);
    expect_pops(0, 8);
    for (int c = 0; c < 50; c++) begin
      tick();
      if (c == 48) req = '0;
      @(negedge rclk);
      eg = ((c % 10) < 8) ? (4'b0001 << ((c / 10) % 4)) : 4'b0000;
      chk("t2_gnt_sequence", 32'(gnt), 32'(eg));
    end

    // Consumer 2 drops req on its 3rd pop; next search starts at 3 and wraps to 0
    do_reset();
    req = 4'b0100;
    expect_pops(2, 3);
    tick();
    req = 4'b0111;
    @(negedge rclk);
    chk("t3_gnt_c2", 32'(gnt), 32'b0100);
    tick();
    @(negedge rclk);
    chk("t3_gnt_c2", 32'(gnt), 32'b0100);
    tick();
    req = 4'b0011;
    @(negedge rclk);
    chk("t3_last_pop_gnt", 32'(gnt), 32'b0100);
    chk("t3_last_pop_rout", 32'(rout), 32'd1);
    tick();
    @(negedge rclk);
    chk("t3_release_gnt", 32'(gnt), 32'd0);
    chk("t3_release_busy", 32'(busy), 32'd1);
    tick();
    @(negedge rclk);
    chk("t3_idle_busy", 32'(busy), 32'd0);
    expect_pops(0, 1);
    tick();
    req = '0;
    @(negedge rclk);
    chk("t3_wrap_gnt", 32'(gnt), 32'b0001);
    tick();
    tick();

    // Granted with FIFO empty: no pop until data arrives, then same-cycle pop
    do_reset();
    wr_cnt = exp_idx;
    req    = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge rclk);
      chk("t4_gnt_hold_empty", 32'(gnt), 32'b0001);
      chk("t4_rout_empty", 32'(rout), 32'd0);
      chk("t4_rd_valid_empty", 32'(rd_valid), 32'd0);
    end
    expect_pops(0, 1);
    tick();
    wr_cnt = exp_idx;
    @(negedge rclk);
    chk("t4_pop_on_fill", 32'(rout), 32'd1);
    tick();
    @(negedge rclk);
    chk("t4_rout_after", 32'(rout), 32'd0);
    chk("t4_gnt_after", 32'(gnt), 32'b0001);
    tick();
    req = '0;
    tick();
    tick();

    // rr now points at 1: reset after 4 pops of consumer 1 must restore priority to 0
    wr_cnt = 1 << 30;
    req    = 4'b1111;
    expect_pops(1, 4);
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge rclk);
      chk("t5_gnt_c1", 32'(gnt), 32'b0010);
    end
    tick();
    rrst_n = 1'b0;
    @(negedge rclk);
    chk("t5_no_pop_in_reset", 32'(rout), 32'd0);
    tick();
    rrst_n = 1'b1;
    @(negedge rclk);
    chk("t5_post_reset_gnt", 32'(gnt), 32'd0);
    chk("t5_post_reset_busy", 32'(busy), 32'd0);
    chk("t5_post_reset_rout", 32'(rout), 32'd0);
    expect_pops(0, 1);
    tick();
    req = '0;
    @(negedge rclk);
    chk("t5_first_gnt_c0", 32'(gnt), 32'b0001);
    tick();
    tick();

`ifdef FIFO_ARB_WDOG_EN
    // Consumer 0 stalls with data available: forced release after TIMEOUT cycles
    do_reset();
    req      = 4'b0011;
    rd_ready = 4'b1110;
    for (int c = 0; c < TIMEOUT; c++) begin
      tick();
      @(negedge rclk);
      chk("t6_stall_gnt", 32'(gnt), 32'b0001);
      chk("t6_stall_rout", 32'(rout), 32'd0);
      chk("t6_wdog_clear", 32'(wdog_err), 32'd0);
    end
    tick();
    @(negedge rclk);
    chk("t6_forced_release", 32'(gnt), 32'd0);
    chk("t6_wdog_set", 32'(wdog_err), 32'd1);
    tick();
    @(negedge rclk);
    chk("t6_idle_gnt", 32'(gnt), 32'd0);
    expect_pops(1, 1);
    tick();
    req = '0;
    @(negedge rclk);
    chk("t6_next_gnt", 32'(gnt), 32'b0010);
    tick();
    tick();
    @(negedge rclk);
    chk("t6_wdog_sticky", 32'(wdog_err), 32'd1);
`endif

    tick();
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
